// File: rtl/bfly_out_merge.sv
// Merges butterfly sum/difference outputs into one stream: each block is HALF plus beats
// passed straight through, then HALF minus beats replayed from a buffer.
module bfly_out_merge #(
  parameter int WIDTH = 23,
  parameter int NUM   = 16,
  parameter int HALF  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   valid_in,
  input  logic [NUM*WIDTH-1:0]   a_re,
  input  logic [NUM*WIDTH-1:0]   a_im,
  input  logic [NUM*WIDTH-1:0]   b_re,
  input  logic [NUM*WIDTH-1:0]   b_im,
  output logic [NUM*WIDTH-1:0]   dout_re,
  output logic [NUM*WIDTH-1:0]   dout_im,
  output logic                   valid_out,
  output logic                   sof_out,
  output logic                   half_sel,
  output logic                   ovf,
  output logic [7:0]             blk_cnt
);

  localparam int VW = NUM * WIDTH;
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(HALF - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [VW-1:0]   dout_re_q, dout_re_d;
  logic [VW-1:0]   dout_im_q, dout_im_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            half_q, half_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      blk_q, blk_d;
  logic            accept_s;

  logic [VW-1:0]   buf_re_q [HALF];
  logic [VW-1:0]   buf_im_q [HALF];

  // Next-state, pointer and output-register decode
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dout_re_d = dout_re_q;
    dout_im_d = dout_im_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    half_d    = 1'b0;
    ovf_d     = ovf_q;
    blk_d     = blk_q;
    accept_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          accept_s = 1'b1;
          sof_d    = 1'b1;
          wr_ptr_d = PTR_ONE;
          state_d  = FILL;
        end else begin
          wr_ptr_d = '0;
        end
      end
      FILL: begin
        if (valid_in) begin
          accept_s = 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      DRAIN: begin
        // Input offered here is dropped; only the sticky flag records it
        valid_d   = 1'b1;
        half_d    = 1'b1;
        dout_re_d = buf_re_q[rd_ptr_q];
        dout_im_d = buf_im_q[rd_ptr_q];
        if (valid_in) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (rd_ptr_q == PTR_LAST) begin
          rd_ptr_d = '0;
          state_d  = IDLE;
          blk_d    = blk_q + 8'd1;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    endcase

    if (accept_s) begin
      dout_re_d = a_re;
      dout_im_d = a_im;
      valid_d   = 1'b1;
    end else begin
      valid_d   = valid_d;
    end

    if (clr) begin
      ovf_d = 1'b0;
      blk_d = 8'd0;
    end else begin
      blk_d = blk_d;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dout_re_q <= '0;
      dout_im_q <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      half_q    <= 1'b0;
      ovf_q     <= 1'b0;
      blk_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dout_re_q <= dout_re_d;
      dout_im_q <= dout_im_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      half_q    <= half_d;
      ovf_q     <= ovf_d;
      blk_q     <= blk_d;
    end
  end

  // Minus-half buffer; left unreset since a block is always fully written before it is read
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_re_q[wr_ptr_q] <= b_re;
      buf_im_q[wr_ptr_q] <= b_im;
    end
  end

  assign dout_re   = dout_re_q;
  assign dout_im   = dout_im_q;
  assign valid_out = valid_q;
  assign sof_out   = sof_q;
  assign half_sel  = half_q;
  assign ovf       = ovf_q;
  assign blk_cnt   = blk_q;

endmodule

// File: tb/tb_bfly_out_merge.sv
// Bench for bfly_out_merge: directed and random traffic compared every cycle against a
// queue-based model of the plus/minus block ordering.
module tb_bfly_out_merge;

  localparam int WIDTH = 23;
  localparam int NUM   = 16;
  localparam int HALF  = 4;
  localparam int VW    = NUM * WIDTH;

  logic          clk = 1'b0;
  logic          rstn, clr, valid_in;
  logic [VW-1:0] a_re, a_im, b_re, b_im;
  logic [VW-1:0] dout_re, dout_im;
  logic          valid_out, sof_out, half_sel, ovf;
  logic [7:0]    blk_cnt;

  int n_chk = 0;
  int n_err = 0;

  bfly_out_merge #(.WIDTH(WIDTH), .NUM(NUM), .HALF(HALF)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .valid_in(valid_in),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .dout_re(dout_re), .dout_im(dout_im),
    .valid_out(valid_out), .sof_out(sof_out), .half_sel(half_sel),
    .ovf(ovf), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic          m_valid, m_sof, m_half, m_ovf;
  logic [7:0]    m_blk;
  logic [VW-1:0] m_re, m_im;
  logic [VW-1:0] pend_re[$];
  logic [VW-1:0] pend_im[$];
  int            drain_left;

  task automatic chk_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < NUM; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input int val);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM; k++) v[k*WIDTH +: WIDTH] = WIDTH'(val);
    return v;
  endfunction

  function automatic logic [VW-1:0] lane0_vec(input int val);
    logic [VW-1:0] v;
    v = rand_vec();
    v[WIDTH-1:0] = WIDTH'(val);
    return v;
  endfunction

  function automatic logic [VW-1:0] extreme_vec(input bit flip);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM; k++)
      v[k*WIDTH +: WIDTH] = (((k % 2) == 1) ^ flip) ? 23'h3FFFFF : 23'h400000;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_sof = 1'b0; m_half = 1'b0; m_ovf = 1'b0;
    m_blk = 8'd0; m_re = '0; m_im = '0;
    pend_re.delete(); pend_im.delete();
    drain_left = 0;
  endtask

  // One clock of the model: plus beats pass through, minus beats replay in arrival order
  task automatic model_step();
    m_valid = 1'b0; m_sof = 1'b0; m_half = 1'b0;
    if (drain_left > 0) begin
      m_valid = 1'b1; m_half = 1'b1;
      m_re = pend_re[HALF - drain_left];
      m_im = pend_im[HALF - drain_left];
      if (valid_in) m_ovf = 1'b1;
      drain_left--;
      if (drain_left == 0) begin
        m_blk = m_blk + 8'd1;
        pend_re.delete(); pend_im.delete();
      end
    end else if (valid_in) begin
      m_valid = 1'b1;
      m_sof = (pend_re.size() == 0);
      m_re = a_re; m_im = a_im;
      pend_re.push_back(b_re); pend_im.push_back(b_im);
      if (pend_re.size() == HALF) drain_left = HALF;
    end
    if (clr) begin
      m_ovf = 1'b0; m_blk = 8'd0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk_val({tag, ".valid"}, VW'(valid_out), VW'(m_valid));
    chk_val({tag, ".sof"},   VW'(sof_out),   VW'(m_sof));
    chk_val({tag, ".half"},  VW'(half_sel),  VW'(m_half));
    chk_val({tag, ".re"},    dout_re,        m_re);
    chk_val({tag, ".im"},    dout_im,        m_im);
    chk_val({tag, ".ovf"},   VW'(ovf),       VW'(m_ovf));
    chk_val({tag, ".blk"},   VW'(blk_cnt),   VW'(m_blk));
  endtask

  task automatic cycle(input string tag, input bit v, input bit c,
                       input logic [VW-1:0] are, input logic [VW-1:0] aim,
                       input logic [VW-1:0] bre, input logic [VW-1:0] bim);
    valid_in = v; clr = c;
    a_re = are; a_im = aim; b_re = bre; b_im = bim;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
  endtask

  task automatic do_reset(input string tag);
    valid_in = 1'b0; clr = 1'b0;
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; valid_in = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    model_reset();
    #1 check_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Single block with lane0 a=1..4, b=-1..-4
    for (int k = 1; k <= HALF; k++)
      cycle("blk1", 1'b1, 1'b0, lane0_vec(k), rand_vec(), lane0_vec(-k), rand_vec());
    idle("blk1_drain", 6);
    chk_val("blk1_cnt", VW'(blk_cnt), VW'(8'd1));

    // Three blocks at full rate
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < HALF; k++)
        cycle("b2b", 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
      idle("b2b_gap", HALF);
    end
    idle("b2b_tail", 2);
    chk_val("b2b_cnt", VW'(blk_cnt), VW'(8'd4));
    chk_val("b2b_ovf", VW'(ovf), VW'(1'b0));

    // Gapped fill 1,0,1,1,0,1
    begin
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++)
        cycle("gap", pat[i], 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    end
    idle("gap_drain", 6);

    // Input offered in the 2nd drain cycle, then clear
    for (int k = 0; k < HALF; k++)
      cycle("ovf_fill", 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    cycle("ovf_d1", 1'b0, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    cycle("ovf_d2", 1'b1, 1'b0, fill_vec(99), fill_vec(99), fill_vec(99), fill_vec(99));
    idle("ovf_tail", 4);
    chk_val("ovf_sticky", VW'(ovf), VW'(1'b1));
    cycle("ovf_clr", 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    chk_val("ovf_cleared", VW'(ovf), VW'(1'b0));
    chk_val("blk_cleared", VW'(blk_cnt), VW'(8'd0));

    // Reset after two accepted beats, then a clean block
    cycle("rst_mid", 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    cycle("rst_mid", 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    do_reset("rst_mid_zero");
    for (int k = 0; k < HALF; k++)
      cycle("post_rst", 1'b1, 1'b0, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    idle("post_rst_drain", 6);

    // Random traffic with occasional clear and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 211) do_reset("rnd_rst");
      cycle("rnd", ($urandom_range(0, 99) < 65), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 7) == 0) ? extreme_vec(1'b0) : rand_vec(), rand_vec(),
            ($urandom_range(0, 7) == 0) ? extreme_vec(1'b1) : rand_vec(), rand_vec());
    end
    idle("rnd_tail", 8);

    // 256 blocks of extreme values: counter wraps to zero
    cycle("wrap_clr", 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    for (int b = 0; b < 256; b++) begin
      for (int k = 0; k < HALF; k++)
        cycle("wrap", 1'b1, 1'b0, extreme_vec(k[0]), extreme_vec(~k[0]),
              extreme_vec(~k[0]), extreme_vec(k[0]));
      idle("wrap_gap", HALF);
    end
    idle("wrap_tail", 2);
    chk_val("wrap_cnt", VW'(blk_cnt), VW'(8'd0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bfly_out_merge.md
BFLY_OUT_MERGE -- requirements
Module: bfly_out_merge

Interface
REQ-001 SHALL have parameter WIDTH, default 23, giving the bit width of each signed lane sample.
REQ-002 SHALL have parameter NUM, default 16, giving the number of parallel lanes.
REQ-003 SHALL have parameter HALF, default 4, giving the number of input beats per block (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of ovf and blk_cnt only.
REQ-007 SHALL have port valid_in, input, 1 bit: the sum and difference inputs are valid this cycle.
REQ-008 SHALL have ports a_re and a_im, input, signed WIDTH x [0:NUM-1]: butterfly sum (plus) outputs.
REQ-009 SHALL have ports b_re and b_im, input, signed WIDTH x [0:NUM-1]: butterfly difference (minus) outputs.
REQ-010 SHALL have ports dout_re and dout_im, output, signed WIDTH x [0:NUM-1]: merged single stream.
REQ-011 SHALL have port valid_out, output, 1 bit: dout is valid this cycle.
REQ-012 SHALL have port sof_out, output, 1 bit: marks the first output beat of a block.
REQ-013 SHALL have port half_sel, output, 1 bit: 0 = plus beat, 1 = minus beat.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag for input offered while draining.
REQ-015 SHALL have port blk_cnt, output, 8 bits: count of completed output blocks.

Function
REQ-016 SHALL implement the FSM states IDLE, FILL and DRAIN; the reset state is IDLE.
REQ-017 IDLE, valid_in=1: SHALL accept beat 0 (wr_ptr=0) and go to FILL; if HALF=1 this would be beat HALF-1, which REQ-003 excludes.
REQ-018 FILL, valid_in=1: SHALL accept a beat at wr_ptr and increment wr_ptr; on wr_ptr=HALF-1 it SHALL go to DRAIN with wr_ptr set to 0.
REQ-019 FILL, valid_in=0: SHALL hold state and pointers; gaps inside a block are legal.
REQ-020 Accepting a beat: SHALL register dout<=a and write buffer[wr_ptr]<=b, visible next cycle with valid_out=1 and half_sel=0.
REQ-021 DRAIN: each cycle SHALL register dout<=buffer[rd_ptr] and increment rd_ptr, visible next cycle with valid_out=1 and half_sel=1.
REQ-022 DRAIN: after the rd_ptr=HALF-1 cycle it SHALL go to IDLE with rd_ptr=0, so DRAIN lasts exactly HALF cycles.
REQ-023 Latency: the plus beat SHALL appear 1 cycle after acceptance; the minus beats SHALL appear contiguously, immediately after the last plus beat.
REQ-024 Minus beat order SHALL equal the plus beat order (buffer index k maps to input beat k).
REQ-025 Output per block SHALL be 2*HALF beats: HALF plus beats, then HALF minus beats.
REQ-026 sof_out SHALL be 1 only on the output of beat 0 (plus half).
REQ-027 Throughput: the first beat of the next block SHALL be accepted in the cycle after the last DRAIN cycle, at earliest HALF+1 cycles after the previous last beat.
REQ-028 valid_in=1 in any DRAIN cycle: SHALL discard the input, write nothing, set ovf=1 and leave the drain undisturbed.
REQ-029 Samples SHALL pass through bit-exact with no width change, rounding or saturation.
REQ-030 When no beat is output: valid_out, sof_out and half_sel SHALL be 0, and dout SHALL hold its last value.
REQ-031 blk_cnt SHALL increment when the last minus beat is registered, wrapping 255 to 0.
REQ-032 clr=1 SHALL zero ovf and blk_cnt next cycle, with priority over a same-cycle set or increment; the FSM and data are unaffected.
REQ-033 The buffer SHALL be HALF entries x NUM lanes x 2 x WIDTH, with an internal write pointer (wr_ptr) and read pointer (rd_ptr).

Reset
REQ-034 rstn=0 SHALL asynchronously force state IDLE, wr_ptr=0, rd_ptr=0, and all outputs to 0: dout, valid_out, sof_out, half_sel, ovf, blk_cnt.
REQ-035 Reset mid-FILL or mid-DRAIN SHALL abandon the partial block; after release the next valid_in SHALL be treated as beat 0.
REQ-036 Buffer contents need not be reset; no stale buffer data SHALL ever appear with valid_out=1.

Verification
REQ-037 SHALL cover (HALF=4) 4 contiguous beats, lane0 a=1..4, b=-1..-4 -> valid_out cycles 1-8, dout_re lane0 = 1,2,3,4,-1,-2,-3,-4; sof_out on cycle 1 only; half_sel=0 for 4 beats then 1 for 4 beats; blk_cnt=1.
REQ-038 SHALL cover back-to-back blocks, each 4 valid cycles then 4 idle cycles, repeated 3 times -> 24 contiguous valid_out beats, ovf=0, blk_cnt=3.
REQ-039 SHALL cover a gapped fill with valid_in pattern 1,0,1,1,0,1 -> plus beats each 1 cycle after acceptance; 4 minus beats directly after the 4th plus beat.
REQ-040 SHALL cover valid_in=1 during the 2nd DRAIN cycle with a=99 -> ovf=1 (sticky); 99 never appears on dout; drain output unchanged; then clr=1 -> ovf=0.
REQ-041 SHALL cover rstn pulsed low after 2 accepted beats -> all outputs 0 immediately; a following 4-beat block outputs the correct 8 beats with sof_out on the first.
REQ-042 SHALL cover 256 blocks -> blk_cnt wraps to 0; values of WIDTH extremes (-2^22 and 2^22-1) pass through bit-exact.
